// File: rtl/soc_system_hex_seg_driver_if.sv
// Avalon-MM control port of the HEX segment driver: 2-bit word address, zero wait states.
interface soc_system_hex_seg_driver_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, output chipselect, output write_n, output writedata,
                  input  readdata);
  modport slave  (input  address, input  chipselect, input  write_n, input  writedata,
                  output readdata);
endinterface

// File: rtl/soc_system_hex_seg_driver.sv
// Drives one 7-segment digit from a HEX PIO pattern: period-aligned pattern latch,
// 16-step PWM brightness, blink and output polarity, with a small Avalon-MM control slave.
module soc_system_hex_seg_driver #(
  parameter int PRESCALE_W = 8,
  parameter int BLINK_W    = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  soc_system_hex_seg_driver_if.slave    bus,
  input  logic [6:0]                    seg_in,
  output logic [6:0]                    hex_n
);

  localparam logic [6:0]         HEX_DARK  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [BLINK_W-1:0] BLINK_ONE = BLINK_W'(1);

  function automatic logic [4:0] sat_duty(input logic [4:0] d);
    return (d > 5'd16) ? 5'd16 : d;
  endfunction

  logic [4:0]            r_duty;
  logic                  r_blink_en;
  logic                  r_enable;
  logic [PRESCALE_W-1:0] r_presc;
  logic [BLINK_W-1:0]    r_blink;
  logic [PRESCALE_W-1:0] r_pcnt;
  logic [3:0]            r_pwm_cnt;
  logic [BLINK_W-1:0]    r_blink_cnt;
  logic                  r_blink_phase;
  logic [6:0]            r_seg_lat;
  logic [6:0]            r_hex_n;

  logic                  w_wr;
  logic                  w_wr_ctrl;
  logic                  w_wr_presc;
  logic                  w_wr_blink;
  logic                  w_tick;
  logic                  w_period_end;
  logic [BLINK_W-1:0]    w_blink_max;
  logic                  w_blink_last;
  logic                  w_lit;
  logic [6:0]            w_seg_on;
  logic [6:0]            w_hex_next;

  assign w_wr       = bus.chipselect & ~bus.write_n;
  assign w_wr_ctrl  = w_wr & (bus.address == 2'd0);
  assign w_wr_presc = w_wr & (bus.address == 2'd1);
  assign w_wr_blink = w_wr & (bus.address == 2'd2);

  assign w_tick       = (r_pcnt == r_presc);
  assign w_period_end = w_tick & (r_pwm_cnt == 4'hF);

  // A zero half-period blinks as if it were one PWM period.
  assign w_blink_max  = (r_blink == '0) ? BLINK_ONE : r_blink;
  assign w_blink_last = (r_blink_cnt == (w_blink_max - BLINK_ONE));

  assign w_lit      = r_enable & ~r_blink_phase & ({1'b0, r_pwm_cnt} < r_duty);
  assign w_seg_on   = w_lit ? r_seg_lat : 7'h00;
  assign w_hex_next = (ACTIVE_LOW != 0) ? ~w_seg_on : w_seg_on;
  assign hex_n      = r_hex_n;

  // Control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_duty     <= 5'd16;
      r_blink_en <= 1'b0;
      r_enable   <= 1'b1;
      r_presc    <= '0;
      r_blink    <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_duty     <= sat_duty(bus.writedata[4:0]);
        r_blink_en <= bus.writedata[5];
        r_enable   <= bus.writedata[6];
      end
      if (w_wr_presc) r_presc <= bus.writedata[PRESCALE_W-1:0];
      if (w_wr_blink) r_blink <= bus.writedata[BLINK_W-1:0];
    end
  end

  // Prescaler, PWM counter and period-aligned pattern latch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pcnt    <= '0;
      r_pwm_cnt <= 4'd0;
      r_seg_lat <= 7'h00;
    end else begin
      if (w_wr_presc || w_tick) r_pcnt <= '0;
      else                      r_pcnt <= r_pcnt + 1'b1;
      if (w_tick)               r_pwm_cnt <= r_pwm_cnt + 4'd1;
      if (w_period_end)         r_seg_lat <= seg_in;
    end
  end

  // Blink state, counted in whole PWM periods
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (!r_blink_en) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      if (w_period_end) begin
        if (w_blink_last) begin
          r_blink_phase <= ~r_blink_phase;
          r_blink_cnt   <= '0;
        end else begin
          r_blink_cnt   <= r_blink_cnt + BLINK_ONE;
        end
      end
      if (w_wr_blink) r_blink_cnt <= '0;
    end
  end

  // Output register: one cycle after counter state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_hex_n <= HEX_DARK;
    else          r_hex_n <= w_hex_next;
  end

  always_comb begin
    bus.readdata = 32'h0;
    case (bus.address)
      2'd0:    bus.readdata = {25'h0, r_enable, r_blink_en, r_duty};
      2'd1:    bus.readdata = 32'(r_presc);
      2'd2:    bus.readdata = 32'(r_blink);
      default: bus.readdata = {20'h0, r_pwm_cnt, r_blink_phase, r_seg_lat};
    endcase
  end

endmodule

// File: tb/tb_soc_system_hex_seg_driver.sv
// Directed bench for the HEX segment driver; expected values are worked out per clock edge.
module tb_soc_system_hex_seg_driver;

  logic       clk;
  logic       reset_n;
  logic [6:0] seg_in;
  logic [6:0] hex_n;
  int         n_chk;
  int         n_fail;
  int         e;
  logic [31:0] rd;
  logic [6:0]  exp_hex;

  soc_system_hex_seg_driver_if bus();

  soc_system_hex_seg_driver dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .seg_in  (seg_in),
    .hex_n   (hex_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic step_to(input int target);
    while (e < target) step();
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    step();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    #1;
    d = bus.readdata;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    e = 0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; e = 0;
    reset_n = 1'b0;
    seg_in = 7'h3F;
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;

    // 1: reset state, dark until first period_end, then steady pattern
    do_reset();
    chk("rst_hex", 32'(hex_n), 32'h7F);
    bus_rd(2'd0, rd); chk("rst_ctrl", rd, 32'h50);
    bus_rd(2'd3, rd); chk("rst_status", rd, 32'h0);
    bus_rd(2'd1, rd); chk("rst_presc", rd, 32'h0);
    for (int n = 0; n < 20; n++) begin
      step();
      chk("t1_hex", 32'(hex_n), (e <= 16) ? 32'h7F : 32'h40);
    end
    reset_n = 1'b0;
    #1;
    chk("t1_async_rst_hex", 32'(hex_n), 32'h7F);

    // 2: duty 4, then duty 0, then duty saturation
    do_reset();
    bus_wr(2'd0, 32'h44);
    while (e < 48) begin
      step();
      exp_hex = (e >= 17 && ((e - 1) % 16) < 4) ? 7'h40 : 7'h7F;
      chk("t2_duty4_hex", 32'(hex_n), 32'(exp_hex));
    end
    bus_wr(2'd0, 32'h40);
    while (e < 66) begin
      step();
      chk("t2_duty0_hex", 32'(hex_n), 32'h7F);
    end
    bus_wr(2'd0, 32'h5F);
    bus_rd(2'd0, rd); chk("t2_duty_sat", rd, 32'h50);

    // 3: mid-period pattern change is held until the period boundary
    seg_in = 7'h06;
    do_reset();
    step_to(16);
    while (e < 21) begin
      step();
      chk("t3_hold_a", 32'(hex_n), 32'h79);
    end
    seg_in = 7'h5B;
    while (e < 32) begin
      step();
      chk("t3_hold_b", 32'(hex_n), 32'h79);
    end
    step();
    chk("t3_new_hex", 32'(hex_n), 32'h24);
    bus_rd(2'd3, rd); chk("t3_status", rd, 32'h15B);

    // 4 + 6: blink with half-period 2, async reset during dark phase
    seg_in = 7'h3F;
    do_reset();
    bus_wr(2'd2, 32'h2);
    bus_wr(2'd0, 32'h70);
    bus_rd(2'd2, rd); chk("t4_blink_reg", rd, 32'h2);
    while (e < 110) begin
      step();
      if (e <= 32)      exp_hex = (e >= 17) ? 7'h40 : 7'h7F;
      else if (e <= 64) exp_hex = 7'h7F;
      else if (e <= 96) exp_hex = 7'h40;
      else              exp_hex = 7'h7F;
      chk("t4_blink_hex", 32'(hex_n), 32'(exp_hex));
    end
    bus_rd(2'd3, rd); chk("t4_status_dark", rd, 32'hEBF);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_hex", 32'(hex_n), 32'h7F);
    bus_rd(2'd0, rd); chk("t6_rst_ctrl", rd, 32'h50);
    bus_rd(2'd2, rd); chk("t6_rst_blink", rd, 32'h0);
    bus_rd(2'd3, rd); chk("t6_rst_status", rd, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    e = 1;
    step_to(17);
    chk("t6_restart_hex", 32'(hex_n), 32'h40);

    // 4b: BLINK=0 behaves as 1
    do_reset();
    bus_wr(2'd0, 32'h70);
    while (e < 64) begin
      step();
      exp_hex = (e >= 33 && e <= 48) ? 7'h40 : 7'h7F;
      chk("t4b_blink0_hex", 32'(hex_n), 32'(exp_hex));
    end

    // 5: prescaler 3, with a mid-count rewrite restarting pcnt
    do_reset();
    bus_wr(2'd1, 32'h3);
    step_to(4);
    bus_rd(2'd3, rd); chk("t5_pwm_e4", rd, 32'h100);
    step_to(5);
    bus_rd(2'd3, rd); chk("t5_pwm_e5", rd, 32'h200);
    step_to(9);
    bus_rd(2'd3, rd); chk("t5_pwm_e9", rd, 32'h300);
    step_to(11);
    bus_wr(2'd1, 32'h3);
    step_to(13);
    bus_rd(2'd3, rd); chk("t5_presc_restart_e13", rd, 32'h300);
    step_to(15);
    bus_rd(2'd3, rd); chk("t5_presc_restart_e15", rd, 32'h300);
    step_to(16);
    bus_rd(2'd3, rd); chk("t5_presc_restart_e16", rd, 32'h400);
    step_to(64);
    chk("t5_hex_e64", 32'(hex_n), 32'h7F);
    step_to(65);
    chk("t5_hex_e65", 32'(hex_n), 32'h40);
    bus_rd(2'd3, rd); chk("t5_status_e65", rd, 32'h03F);
    step_to(127);
    bus_rd(2'd3, rd); chk("t5_status_e127", rd, 32'hF3F);
    step_to(128);
    bus_rd(2'd3, rd); chk("t5_status_e128", rd, 32'h03F);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
